// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo
// Packet-aware synchronous FIFO for one router output channel. Each stored
// word is {lfd, data}; the lfd bit lets the read side rebuild packet
// boundaries (sop_out/eop_out) and flag framing errors (frame_err).
//
// Ports:
//   clk, reset (sync, active-high), soft_reset (sync flush, second priority)
//   write_enb, lfd_state, data_in : write side
//   read_enb                      : read request
//   data_out, data_valid, sop_out, eop_out : registered read results
//   empty, full, almost_full, count : occupancy (flags decoded from count)
//   pkt_count                     : headers stored and not yet read
//   overflow_err, frame_err       : one-cycle error pulses
//
// Handshake: a write is accepted when write_enb && (!full || a read is
// accepted in the same cycle); a rejected write pulses overflow_err and
// changes nothing. A read is accepted when read_enb && !empty; a read on
// empty is ignored silently. Accepted reads show up on data_out with
// data_valid one cycle later.
module router_pkt_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     soft_reset,
   input  logic                     write_enb,
   input  logic                     lfd_state,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     read_enb,
   output logic [DATA_W-1:0]        data_out,
   output logic                     data_valid,
   output logic                     sop_out,
   output logic                     eop_out,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   pkt_count,
   output logic                     overflow_err,
   output logic                     frame_err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int LEN_W = DATA_W - 2;

   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]  AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   localparam logic [AW-1:0]  PTR_ONE = AW'(1);
   localparam logic [LEN_W:0] RC_ONE  = (LEN_W+1)'(1);

   // Storage is not cleared by reset; only pointers and counters are.
   logic [DATA_W:0] mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic [LEN_W:0]    rd_cnt_q, rd_cnt_d;   // words left in current packet
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              dv_q, dv_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic              ovf_q, ovf_d;
   logic              ferr_q, ferr_d;

   logic              flush;
   logic              rd_acc, wr_acc;
   logic [DATA_W:0]   rd_word;
   logic              rd_lfd;

   assign flush   = reset | soft_reset;
   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign almost_full = (count_q >= AF_C);

   assign rd_acc  = read_enb & ~empty;
   assign wr_acc  = write_enb & (~full | rd_acc);
   assign rd_word = mem_q[rd_ptr_q];
   assign rd_lfd  = rd_word[DATA_W];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pkt_cnt_d  = pkt_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      data_out_d = data_out_q;
      dv_d       = 1'b0;
      sop_d      = 1'b0;
      eop_d      = 1'b0;
      ferr_d     = 1'b0;
      ovf_d      = write_enb & ~wr_acc;

      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case ({wr_acc & lfd_state, rd_acc & rd_lfd})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
         2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase

      if (rd_acc) begin
         data_out_d = rd_word[DATA_W-1:0];
         dv_d       = 1'b1;
         if (rd_lfd) begin
            // Header: remaining words = payload_len + parity.
            rd_cnt_d = (LEN_W+1)'(rd_word[DATA_W-1:2]) + RC_ONE;
            sop_d    = 1'b1;
            ferr_d   = (rd_cnt_q != '0);
         end else if (rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - RC_ONE;
            eop_d    = (rd_cnt_q == RC_ONE);
         end else begin
            // Orphan word outside any packet.
            ferr_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !flush) mem_q[wr_ptr_q] <= {lfd_state, data_in};
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_cnt_q  <= '0;
         rd_cnt_q   <= '0;
         data_out_q <= '0;
         dv_q       <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_cnt_q  <= pkt_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         data_out_q <= data_out_d;
         dv_q       <= dv_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         ovf_q      <= ovf_d;
         ferr_q     <= ferr_d;
      end
   end

   assign data_out     = data_out_q;
   assign data_valid   = dv_q;
   assign sop_out      = sop_q;
   assign eop_out      = eop_q;
   assign count        = count_q;
   assign pkt_count    = pkt_cnt_q;
   assign overflow_err = ovf_q;
   assign frame_err    = ferr_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo (DATA_W=8, DEPTH=16, AF_LEVEL=14).
module tb_router_pkt_fifo;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset, soft_reset, write_enb, lfd_state, read_enb;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_valid, sop_out, eop_out, empty, full, almost_full;
   logic [4:0] count, pkt_count;
   logic       overflow_err, frame_err;

   always #5 clk = ~clk;

   router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14)) dut (
      .clk(clk), .reset(reset), .soft_reset(soft_reset),
      .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
      .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
      .sop_out(sop_out), .eop_out(eop_out), .empty(empty), .full(full),
      .almost_full(almost_full), .count(count), .pkt_count(pkt_count),
      .overflow_err(overflow_err), .frame_err(frame_err)
   );

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- drivers ----------------
   // Apply inputs for one clock edge, then sample 1 time unit after it.
   task automatic drive(input logic we, input logic lfd, input logic [7:0] din,
                        input logic re, input logic sr);
      write_enb  = we;
      lfd_state  = lfd;
      data_in    = din;
      read_enb   = re;
      soft_reset = sr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] d, input logic lfd);
      drive(1'b1, lfd, d, 1'b0, 1'b0);
      exp_q.push_back(d);
   endtask

   task automatic rd_chk(input logic s, input logic e, input logic f);
      logic [7:0] x;
      x = exp_q.pop_front();
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("rd_valid", data_valid, 1'b1);
      chk("rd_data", data_out, x);
      chk("rd_sop", sop_out, s);
      chk("rd_eop", eop_out, e);
      chk("rd_frame_err", frame_err, f);
   endtask

   // Header 8'h39 = len 14, addr 01; 14 payloads; parity: 16 words total.
   task automatic fill_pkt39();
      logic [7:0] d;
      for (int i = 0; i < 16; i++) begin
         d = (i == 0) ? 8'h39 : 8'($urandom_range(0, 255));
         wr(d, i == 0);
         chk("fill_count", count, i + 1);
         chk("fill_af", almost_full, (i + 1) >= 14);
         chk("fill_full", full, (i + 1) == 16);
      end
      chk("fill_pkt", pkt_count, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] x;
      logic [7:0] wd [4];
      logic       wl [4];
      logic       ws [4];
      int         wp [4];
      wd = '{8'h02, 8'hA5, 8'h02, 8'hA5};
      wl = '{1'b1, 1'b0, 1'b1, 1'b0};
      ws = '{1'b1, 1'b0, 1'b0, 1'b0};
      wp = '{1, 1, 2, 2};

      reset = 1'b1;
      write_enb = 0; lfd_state = 0; data_in = 0; read_enb = 0; soft_reset = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_valid", data_valid, 0);
      chk("rst_sop", sop_out, 0);
      chk("rst_eop", eop_out, 0);
      chk("rst_count", count, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ovf", overflow_err, 0);
      chk("rst_ferr", frame_err, 0);

      // Fill to full, then one rejected write.
      fill_pkt39();
      drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      chk("ovf_pulse", overflow_err, 1);
      chk("ovf_count", count, 16);
      idle();
      chk("ovf_one_cycle", overflow_err, 0);

      // Drain the packet.
      for (int i = 0; i < 16; i++) rd_chk(i == 0, i == 15, 1'b0);
      chk("drain_empty", empty, 1);
      chk("drain_pkt", pkt_count, 0);
      x = data_out;
      idle();
      chk("hold_valid", data_valid, 0);
      chk("hold_data", data_out, x);

      // Read on empty is silently ignored.
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("rd_empty_valid", data_valid, 0);
      chk("rd_empty_ferr", frame_err, 0);
      chk("rd_empty_count", count, 0);

      // Full with simultaneous read and write for 4 cycles.
      fill_pkt39();
      for (int i = 0; i < 4; i++) begin
         x = exp_q.pop_front();
         exp_q.push_back(wd[i]);
         drive(1'b1, wl[i], wd[i], 1'b1, 1'b0);
         chk("both_valid", data_valid, 1);
         chk("both_data", data_out, x);
         chk("both_sop", sop_out, ws[i]);
         chk("both_count", count, 16);
         chk("both_full", full, 1);
         chk("both_ovf", overflow_err, 0);
         chk("both_pkt", pkt_count, wp[i]);
      end
      for (int i = 0; i < 11; i++) rd_chk(1'b0, 1'b0, 1'b0);
      rd_chk(1'b0, 1'b1, 1'b0);
      rd_chk(1'b1, 1'b0, 1'b0);
      rd_chk(1'b0, 1'b1, 1'b0);
      rd_chk(1'b1, 1'b0, 1'b0);
      rd_chk(1'b0, 1'b1, 1'b0);
      chk("both_drain_empty", empty, 1);
      chk("both_drain_pkt", pkt_count, 0);

      // Length-0 packet, then a truncated packet followed by a new header.
      wr(8'h02, 1'b1);
      wr(8'hA5, 1'b0);
      rd_chk(1'b1, 1'b0, 1'b0);
      rd_chk(1'b0, 1'b1, 1'b0);
      wr(8'h0D, 1'b1);
      wr(8'h5A, 1'b0);
      wr(8'h0D, 1'b1);
      rd_chk(1'b1, 1'b0, 1'b0);
      rd_chk(1'b0, 1'b0, 1'b0);
      rd_chk(1'b1, 1'b0, 1'b1);
      idle();
      chk("ferr_one_cycle", frame_err, 0);

      // Five words, read two (the header still sees the unfinished packet), then flush.
      wr(8'h0D, 1'b1);
      wr(8'h10, 1'b0);
      wr(8'h20, 1'b0);
      wr(8'h30, 1'b0);
      wr(8'h40, 1'b0);
      chk("pre_sr_pkt", pkt_count, 1);
      rd_chk(1'b1, 1'b0, 1'b1);
      rd_chk(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
      exp_q.delete();
      chk("sr_count", count, 0);
      chk("sr_empty", empty, 1);
      chk("sr_pkt", pkt_count, 0);
      chk("sr_valid", data_valid, 0);
      chk("sr_data", data_out, 8'h00);
      idle();
      chk("sr_write_dropped", count, 0);

      // Post-flush header is clean; then finish it and read an orphan word.
      wr(8'h06, 1'b1);
      rd_chk(1'b1, 1'b0, 1'b0);
      wr(8'h11, 1'b0);
      wr(8'h22, 1'b0);
      rd_chk(1'b0, 1'b0, 1'b0);
      rd_chk(1'b0, 1'b1, 1'b0);
      wr(8'h33, 1'b0);
      rd_chk(1'b0, 1'b0, 1'b1);
      chk("end_empty", empty, 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware synchronous FIFO for the 1x3 router output channels, the next generation of the fixed 16x8 router FIFO. It buffers header/payload/parity bytes written by the FSM/synchroniser side and returns them to the output port on request. Each stored word carries the header-marker bit, so the read side can rebuild packet boundaries (SOP/EOP) and flag framing errors. The block adds configurable width and depth, an occupancy count, almost-full, a stored-packet count and error pulses.

## Interface
Parameters:
- DATA_W, 8, data width; header format {payload_len[DATA_W-1:2], addr[1:0]}
- DEPTH, 16, entries; power of two, >= 4
- AF_LEVEL, DEPTH-2, almost_full threshold; 1..DEPTH

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high; highest priority
- soft_reset  in  1  synchronous, active-high flush; second priority
- write_enb  in  1  write request
- lfd_state  in  1  marks data_in as the packet header; stored with the word
- data_in  in  DATA_W  write data
- read_enb  in  1  read request
- data_out  out  DATA_W  registered read data
- data_valid  out  1  data_out updated this cycle
- sop_out  out  1  data_out is a header word
- eop_out  out  1  data_out is the last word (parity) of the packet
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- count  out  $clog2(DEPTH)+1  occupancy
- pkt_count  out  $clog2(DEPTH)+1  headers stored and not yet read
- overflow_err  out  1  one-cycle pulse: write rejected
- frame_err  out  1  one-cycle pulse: header read before previous packet ended

## Operation
- Storage: DEPTH x (DATA_W+1) array of {lfd, data}. Write and read pointers are log2(DEPTH) bits and wrap naturally. The array is not cleared by reset.
- Write accept: write_enb && (!full || read accept in the same cycle). A rejected write pulses overflow_err and changes no state.
- Read accept: read_enb && !empty. A read on empty is ignored silently, with no error.
- count: +1 on write only, -1 on read only, unchanged on both.
- pkt_count: +1 on an accepted write with lfd_state=1, -1 on an accepted read of a stored lfd word. Both in one cycle leaves it unchanged.
- Read framing uses the remaining-word counter rd_cnt (LEN_W+1 bits):
  - Reading an lfd word: rd_cnt <= payload_len+1; sop_out=1. If rd_cnt != 0 before the load, frame_err pulses.
  - Reading a non-lfd word with rd_cnt != 0: rd_cnt decrements. If rd_cnt == 1, eop_out=1.
  - Reading a non-lfd word with rd_cnt == 0 (orphan word): data_valid=1, sop_out=0, eop_out=0, frame_err pulses.
- reset or soft_reset sets pointers, count, pkt_count and rd_cnt to 0, and clears data_out, data_valid, sop_out, eop_out, overflow_err and frame_err. Any write or read in the same cycle is discarded.

## Timing
- Reset values: data_out=0, data_valid=0, sop_out=0, eop_out=0, count=0, pkt_count=0, empty=1, full=0, almost_full=0, overflow_err=0, frame_err=0.
- All outputs are registers or decodes of registers. empty, full and almost_full are decoded from the count register.
- Write latency: a word written at edge N is readable, with empty=0, from cycle N+1. There is no write-to-read bypass when empty.
- Read latency: a read accepted at edge N puts data_out, data_valid, sop_out and eop_out up in cycle N+1.
- data_valid, sop_out, eop_out and the error pulses last exactly one cycle per event. data_out holds its last value when data_valid=0.
- Full with read and write in the same cycle: both are accepted, count stays DEPTH, no overflow.
- Empty with read and write in the same cycle: the write is accepted, the read is ignored, count becomes 1.
- soft_reset mid-packet: the FIFO is empty the next cycle, and the next word read must be a header to avoid frame_err.

## Test plan
Bench settings: DATA_W=8, DEPTH=16, AF_LEVEL=14.
- reset high for 2 cycles, then low -> all outputs at their reset values; empty=1, count=0.
- Write header 8'h39 (len 14, addr 01, lfd=1), 14 random payload bytes, then parity (16 words) -> almost_full=1 from count=14, full=1 at count=16, pkt_count=1. A 17th write -> overflow_err pulse, count stays 16.
- Read the 16 words -> first data_out=8'h39 with sop_out=1; 16th word = parity with eop_out=1; empty=1 after; pkt_count=0.
- While full, hold read_enb=1 and write_enb=1 for 4 cycles -> count stays 16, 4 data_valid pulses, no overflow_err.
- Write 8'h02 (len 0, lfd) then parity 8'hA5; read both -> sop_out on 8'h02, eop_out on 8'hA5 in the next valid cycle. Write header 8'h0D (len 3), 1 payload byte, then header 8'h0D again; read all three -> frame_err on the second header.
- Write 5 words, read 2, assert soft_reset together with write_enb=1 -> count=0, empty=1, pkt_count=0 next cycle, no data_valid. A following header read -> sop_out=1, no frame_err.
